// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA framebuffer path.
//
// Contents:
//   pixel_t        one 12-bit pixel, {b[11:8], g[7:4], r[3:0]}
//   pix_group_t    one fetch group of GROUP_PIX pixels, entry i = pixel i
//   fetch_state_t  state encoding of the fetch stage FSM
//   H_ACTIVE, V_ACTIVE, GROUP_PIX, NUM_GROUPS  visible raster geometry
package vga_pkg;

  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int GROUP_PIX  = 32;
  localparam int NUM_GROUPS = H_ACTIVE / GROUP_PIX;

  typedef logic [11:0] pixel_t;
  typedef pixel_t [GROUP_PIX-1:0] pix_group_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/vga_fetch_addr.sv
// Combinational framebuffer address calculator: (line, group) -> word
// address of the first pixel of that group.
//
// Ports:
//   y        in  9       line number 0..479
//   x_group  in  5       group index 0..19
//   base     out ADDR_W  FB_BASE + y*LINE_PIX + x_group*GROUP_PIX
//
// A 640-pixel stride is built from two shifts (512 + 128) so no multiplier
// is needed for the standard mode; other strides fall back to a multiply.
// GROUP_PIX must be a power of two.
module vga_fetch_addr #(
  parameter int ADDR_W    = 19,
  parameter int FB_BASE   = 0,
  parameter int LINE_PIX  = 640,
  parameter int GROUP_PIX = 32
) (
  input  logic [8:0]        y,
  input  logic [4:0]        x_group,
  output logic [ADDR_W-1:0] base
);

  localparam int GROUP_SH = $clog2(GROUP_PIX);

  logic [ADDR_W-1:0] y_ext;
  logic [ADDR_W-1:0] g_ext;
  logic [ADDR_W-1:0] line_off;
  logic [ADDR_W-1:0] group_off;

  assign y_ext = ADDR_W'(y);
  assign g_ext = ADDR_W'(x_group);

  generate
    if (LINE_PIX == 640) begin : g_shift_stride
      assign line_off = (y_ext << 9) + (y_ext << 7);
    end else begin : g_mul_stride
      assign line_off = y_ext * ADDR_W'(LINE_PIX);
    end
  endgenerate

  assign group_off = g_ext << GROUP_SH;
  assign base      = ADDR_W'(FB_BASE) + line_off + group_off;

endmodule

// File: rtl/vga_fetch.sv
// Framebuffer fetch stage feeding the VGA scan-out block.
//
// Watches the scan-out fetch tuple (en, x_group, y). Whenever the tuple
// changes to an enabled one, the 32 pixels of that group are read from the
// framebuffer into a shadow buffer. When the tuple is left again (the moment
// the scan-out starts displaying that group) the shadow buffer is published
// on mem_bgr_buf with a one-cycle mem_stb.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   mem_fetch_en        fetch requested for the current tuple
//   mem_fetch_x_group   group index 0..19
//   mem_fetch_y_val     line 0..479
//   fb_req / fb_addr    read request and word address (registered)
//   fb_gnt              request accepted this cycle
//   fb_rvalid/fb_rdata  read response, returned in request order
//   mem_bgr_buf         published group, entry i = pixel i
//   mem_stb             one-cycle publish strobe
//   underrun            sticky: a group was published incomplete
//   fsm_state           current fetch FSM state (observation only)
//
// Read port handshake: a request is transferred in every cycle where
// fb_req && fb_gnt. fb_req/fb_addr stay stable until that happens. Each
// transferred request produces exactly one later fb_rvalid beat, in order.
// fb_rvalid with no request outstanding is ignored.
module vga_fetch
  import vga_pkg::*;
#(
  parameter int ADDR_W    = 19,
  parameter int FB_BASE   = 0,
  parameter int LINE_PIX  = 640,
  parameter int GROUP_PIX = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_fetch_en,
  input  logic [4:0]         mem_fetch_x_group,
  input  logic [8:0]         mem_fetch_y_val,
  output logic               fb_req,
  output logic [ADDR_W-1:0]  fb_addr,
  input  logic               fb_gnt,
  input  logic               fb_rvalid,
  input  logic [11:0]        fb_rdata,
  output pix_group_t         mem_bgr_buf,
  output logic               mem_stb,
  output logic               underrun,
  output fetch_state_t       fsm_state
);

  localparam logic [5:0] FULL = 6'(GROUP_PIX);

  // Previous tuple, updated every cycle.
  logic       prev_en;
  logic [4:0] prev_group;
  logic [8:0] prev_y;

  logic tuple_change;
  logic do_publish;
  logic do_start;

  fetch_state_t      state, state_n;
  logic [5:0]        issue_cnt, issue_n;
  logic [5:0]        ret_cnt, ret_n;
  logic [5:0]        pend_cnt, pend_n;
  logic [ADDR_W-1:0] base_q, base_n, base_in;
  logic              fb_req_n;
  logic [ADDR_W-1:0] fb_addr_n;

  pix_group_t shadow;
  pix_group_t merged;

  logic       grant;
  logic       beat;
  logic       fetch_beat;
  logic [5:0] ret_total;

  // Base address of the incoming tuple; latched on a fetch start.
  vga_fetch_addr #(
    .ADDR_W    (ADDR_W),
    .FB_BASE   (FB_BASE),
    .LINE_PIX  (LINE_PIX),
    .GROUP_PIX (GROUP_PIX)
  ) u_addr (
    .y       (mem_fetch_y_val),
    .x_group (mem_fetch_x_group),
    .base    (base_in)
  );

  assign tuple_change = (mem_fetch_en != prev_en) ||
                        (mem_fetch_en && ((mem_fetch_x_group != prev_group) ||
                                          (mem_fetch_y_val   != prev_y)));
  assign do_publish   = tuple_change && prev_en;
  assign do_start     = tuple_change && mem_fetch_en;

  assign grant      = fb_req && fb_gnt;
  // Outstanding count gates responses: stray beats (e.g. right after reset)
  // cannot corrupt the counters or the shadow buffer.
  assign beat       = fb_rvalid && (pend_cnt != 6'd0);
  // Only beats belonging to the live fetch land in the shadow buffer; beats
  // seen in DRAIN or IDLE belong to an abandoned fetch.
  assign fetch_beat = beat && (state == FETCH);

  assign pend_n    = pend_cnt + {5'd0, grant} - {5'd0, beat};
  assign ret_total = ret_cnt + {5'd0, fetch_beat};

  assign fsm_state = state;

  // Shadow contents as they would look after this cycle's beat, so a beat
  // arriving in the publish cycle is not lost.
  always_comb begin
    merged = shadow;
    if (fetch_beat) begin
      merged[ret_cnt[4:0]] = fb_rdata;
    end
  end

  // Next-state logic. A start always wins: it restarts the counters and
  // either fetches immediately or first drains reads of the old tuple.
  always_comb begin
    state_n = state;
    issue_n = issue_cnt;
    ret_n   = ret_cnt;
    base_n  = base_q;
    if (do_start) begin
      base_n  = base_in;
      issue_n = 6'd0;
      ret_n   = 6'd0;
      state_n = (pend_n == 6'd0) ? FETCH : DRAIN;
    end else if (tuple_change) begin
      // Enable dropped: abandon the fetch; outstanding beats are still
      // counted off by pend_cnt and discarded.
      state_n = IDLE;
    end else begin
      case (state)
        FETCH: begin
          if (grant) begin
            issue_n = issue_cnt + 6'd1;
          end
          if (fetch_beat) begin
            ret_n = ret_cnt + 6'd1;
          end
          if (ret_n == FULL) begin
            state_n = IDLE;
          end
        end
        DRAIN: begin
          if (pend_n == 6'd0) begin
            state_n = FETCH;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Request outputs are registered: derived from next state so the request
  // for the following address appears right after a grant.
  always_comb begin
    fb_req_n  = (state_n == FETCH) && (issue_n < FULL);
    fb_addr_n = '0;
    if (fb_req_n) begin
      fb_addr_n = base_n + ADDR_W'(issue_n);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_en     <= 1'b0;
      prev_group  <= 5'd0;
      prev_y      <= 9'd0;
      state       <= IDLE;
      issue_cnt   <= 6'd0;
      ret_cnt     <= 6'd0;
      pend_cnt    <= 6'd0;
      base_q      <= '0;
      fb_req      <= 1'b0;
      fb_addr     <= '0;
      shadow      <= '0;
      mem_bgr_buf <= '0;
      mem_stb     <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      prev_en    <= mem_fetch_en;
      prev_group <= mem_fetch_x_group;
      prev_y     <= mem_fetch_y_val;
      state      <= state_n;
      issue_cnt  <= issue_n;
      ret_cnt    <= ret_n;
      pend_cnt   <= pend_n;
      base_q     <= base_n;
      fb_req     <= fb_req_n;
      fb_addr    <= fb_addr_n;

      if (fetch_beat) begin
        shadow[ret_cnt[4:0]] <= fb_rdata;
      end

      mem_stb <= do_publish;
      if (do_publish) begin
        mem_bgr_buf <= merged;
        // Unreturned entries keep whatever the shadow held before.
        if (ret_total < FULL) begin
          underrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_fetch.sv
// Bench for vga_fetch: table of single-group fetches, full-line sweep,
// simultaneous last-beat/publish, grant stall, and underrun with drain.
// Published groups are checked against a queue of expected buffers pushed
// whenever the driven tuple is left.
module tb_vga_fetch;
  import vga_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic         mem_fetch_en = 1'b0;
  logic [4:0]   mem_fetch_x_group = 5'd0;
  logic [8:0]   mem_fetch_y_val = 9'd0;
  logic         fb_req;
  logic [18:0]  fb_addr;
  logic         fb_gnt;
  logic         fb_rvalid;
  logic [11:0]  fb_rdata;
  pix_group_t   mem_bgr_buf;
  logic         mem_stb;
  logic         underrun;
  fetch_state_t fsm_state;

  vga_fetch dut (
    .clk               (clk),
    .rst               (rst),
    .mem_fetch_en      (mem_fetch_en),
    .mem_fetch_x_group (mem_fetch_x_group),
    .mem_fetch_y_val   (mem_fetch_y_val),
    .fb_req            (fb_req),
    .fb_addr           (fb_addr),
    .fb_gnt            (fb_gnt),
    .fb_rvalid         (fb_rvalid),
    .fb_rdata          (fb_rdata),
    .mem_bgr_buf       (mem_bgr_buf),
    .mem_stb           (mem_stb),
    .underrun          (underrun),
    .fsm_state         (fsm_state)
  );

  // ---------------- memory model ----------------
  // Grant is combinational on fb_req; responses one cycle later,
  // data = low 12 bits of the granted address.
  int   cyc = 0;
  logic stall = 1'b0;
  logic slow = 1'b0;
  logic rv_force = 1'b0;
  logic rv_q = 1'b0;
  logic [11:0] rd_q = 12'd0;
  int   grants = 0;
  int   beats = 0;

  assign fb_gnt    = fb_req && !stall && (!slow || (cyc % 8 == 0));
  assign fb_rvalid = rv_q || rv_force;
  assign fb_rdata  = rv_force ? 12'hABC : rd_q;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fb_req && fb_gnt) grants <= grants + 1;
    if (fb_rvalid) beats <= beats + 1;
    if (!rst) begin
      rv_q <= 1'b0;
      rd_q <= 12'd0;
    end else begin
      rv_q <= fb_req && fb_gnt;
      rd_q <= fb_addr[11:0];
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int stb_cnt = 0;
  logic [383:0] exp_q[$];

  task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [18:0] ref_base(input int y, input int g);
    return 19'(y * 640 + g * 32);
  endfunction

  function automatic pix_group_t group_data(input logic [18:0] base);
    pix_group_t gd;
    for (int i = 0; i < 32; i++) begin
      logic [18:0] a;
      a = base + 19'(i);
      gd[i] = a[11:0];
    end
    return gd;
  endfunction

  // Bench view of the current tuple and its expected buffer.
  logic        b_en = 1'b0;
  logic [4:0]  b_g = 5'd0;
  logic [8:0]  b_y = 9'd0;
  pix_group_t  cur_exp = '0;
  logic [18:0] cur_base = 19'd0;
  int          grant_snap = 0;
  int          beat_snap = 0;
  int          chg_cyc = -1;

  always @(negedge clk) begin
    if (rst && fb_req && fb_gnt && cyc != chg_cyc) begin
      logic [18:0] ea;
      ea = cur_base + 19'(grants - grant_snap);
      check("fb_addr_seq", fb_addr, ea);
    end
    if (rst && mem_stb) begin
      stb_cnt++;
      if (exp_q.size() == 0) check("stb_unexpected", 1, 0);
      else check("mem_bgr_buf", mem_bgr_buf, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a new tuple; called just after a rising edge.
  task automatic set_tuple(input logic e, input logic [4:0] g, input logic [8:0] y);
    logic chg;
    chg = (e != b_en) || (e && (g != b_g || y != b_y));
    if (chg && b_en) exp_q.push_back(cur_exp);
    if (chg && e) begin
      cur_base   = ref_base(int'(y), int'(g));
      cur_exp    = group_data(cur_base);
      grant_snap = grants + ((fb_req && fb_gnt) ? 1 : 0);
      beat_snap  = beats + (fb_rvalid ? 1 : 0);
      chg_cyc    = cyc;
    end
    b_en = e; b_g = g; b_y = y;
    mem_fetch_en = e; mem_fetch_x_group = g; mem_fetch_y_val = y;
  endtask

  typedef struct {
    logic [8:0]  y;
    logic [4:0]  g;
    logic [18:0] base;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[7];
    pix_group_t a_data;
    int stb0;
    int ret;
    bit found;

    vecs[0] = '{9'd5,   5'd3,  19'd3296};
    vecs[1] = '{9'd5,   5'd4,  19'd3328};
    vecs[2] = '{9'd0,   5'd0,  19'd0};
    vecs[3] = '{9'd479, 5'd19, 19'd307168};
    vecs[4] = '{9'd1,   5'd1,  19'd672};
    vecs[5] = '{9'd255, 5'd19, 19'd163808};
    vecs[6] = '{9'd256, 5'd0,  19'd163840};

    // Reset with stray responses forced in.
    rv_force = 1'b1;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_fb_req", fb_req, 0);
      check("rst_fb_addr", fb_addr, 0);
      check("rst_mem_stb", mem_stb, 0);
      check("rst_buf", mem_bgr_buf, 0);
      check("rst_underrun", underrun, 0);
      check("rst_state", fsm_state, IDLE);
      tick(1);
    end
    rv_force = 1'b0;
    rst = 1'b1;
    tick(2);

    // Table: single-group fetches; each change publishes the previous one.
    for (int i = 0; i < 7; i++) begin
      set_tuple(1'b1, vecs[i].g, vecs[i].y);
      @(negedge clk);
      check("stb_early", mem_stb, 0);
      tick(1);
      @(negedge clk);
      check("fb_req_start", fb_req, 1);
      check("base_addr", fb_addr, vecs[i].base);
      check("stb_pulse", mem_stb, (i > 0));
      tick(1);
      @(negedge clk);
      check("stb_once", mem_stb, 0);
      tick(36);
      check("fetch_done", fsm_state, IDLE);
      check("no_underrun", underrun, 0);
    end
    set_tuple(1'b0, 5'd0, 9'd256);
    tick(4);

    // Full line y=0, 4 clocks per pixel tick.
    stb0 = stb_cnt;
    for (int g = 0; g < 20; g++) begin
      set_tuple(1'b1, 5'(g), 9'd0);
      tick(128);
    end
    set_tuple(1'b0, 5'd19, 9'd0);
    tick(4);
    check("line_stb_count", 32'(stb_cnt - stb0), 20);
    check("line_queue_empty", 32'(exp_q.size()), 0);

    // 32nd beat arrives in the same cycle as the tuple change.
    set_tuple(1'b1, 5'd7, 9'd100);
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      tick(1);
      if ((beats - beat_snap) == 31 && fb_rvalid) found = 1;
    end
    check("simul_reached", found, 1);
    set_tuple(1'b1, 5'd8, 9'd100);
    tick(2);
    check("simul_underrun", underrun, 0);
    tick(40);

    // Grant stall at issue 7.
    set_tuple(1'b1, 5'd2, 9'd50);
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      tick(1);
      if ((grants - grant_snap) == 7) found = 1;
    end
    check("stall_reached", found, 1);
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_req", fb_req, 1);
      check("stall_addr", fb_addr, ref_base(50, 2) + 19'd7);
      tick(1);
    end
    stall = 1'b0;
    tick(40);
    check("stall_done", fsm_state, IDLE);

    // Underrun: A=(3,50) fills the shadow, B=(4,60) fetched slowly and
    // abandoned after 10 beats with one read in flight.
    set_tuple(1'b1, 5'd3, 9'd50);
    tick(40);
    a_data = group_data(ref_base(50, 3));
    slow = 1'b1;
    set_tuple(1'b1, 5'd4, 9'd60);
    found = 0;
    for (int k = 0; k < 400 && !found; k++) begin
      tick(1);
      if ((beats - beat_snap) >= 10 && (cyc % 8 == 0) && fb_req) found = 1;
    end
    check("underrun_reached", found, 1);
    ret = beats - beat_snap;
    check("underrun_ret10", 32'(ret), 10);
    for (int i = 0; i < 32; i++) begin
      if (i >= ret) cur_exp[i] = a_data[i];
    end
    set_tuple(1'b1, 5'd5, 9'd60);
    tick(1);
    @(negedge clk);
    check("drain_no_req", fb_req, 0);
    check("drain_beat", fb_rvalid, 1);
    check("drain_state", fsm_state, DRAIN);
    check("underrun_stb", mem_stb, 1);
    check("underrun_set", underrun, 1);
    tick(1);
    slow = 1'b0;
    @(negedge clk);
    check("refetch_req", fb_req, 1);
    check("refetch_addr", fb_addr, ref_base(60, 5));
    tick(40);
    check("underrun_sticky", underrun, 1);
    set_tuple(1'b0, 5'd5, 9'd60);
    tick(4);
    check("underrun_sticky2", underrun, 1);
    check("queue_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_fetch.md
Name: vga_fetch

Overview:
- Framebuffer fetch stage directly upstream of the VGA timing/scan-out block.
- Watches the scan-out block's fetch request (mem_fetch_en, mem_fetch_x_group, mem_fetch_y_val).
- Reads the 32 pixels of the requested group from framebuffer memory through a req/gnt/rvalid read port.
- Publishes each completed 32-pixel group as mem_bgr_buf, with a one-cycle mem_stb, exactly when that group becomes the displayed group.

Parameters:
- ADDR_W, 19, framebuffer word-address width.
- FB_BASE, 0, word address of pixel (0,0).
- LINE_PIX, 640, pixels per framebuffer line (address stride per y).
- GROUP_PIX, 32, pixels per fetch group (fixed; must match scan-out buffer depth).

Ports:
- clk  in  1  base clock (same clock as scan-out).
- rst  in  1  synchronous, active-low reset.
- mem_fetch_en  in  1  a fetch is requested for the current tuple.
- mem_fetch_x_group  in  5  group index 0..19.
- mem_fetch_y_val  in  9  line 0..479.
- fb_req  out  1  read request.
- fb_addr  out  ADDR_W  read word address, valid while fb_req=1.
- fb_gnt  in  1  request accepted this cycle.
- fb_rvalid  in  1  read data valid; responses return in request order.
- fb_rdata  in  12  pixel word, {b[11:8], g[7:4], r[3:0]}.
- mem_bgr_buf  out  [31:0][11:0]  published group; entry i = pixel i of the group.
- mem_stb  out  1  one-cycle publish strobe.
- underrun  out  1  sticky: a group was published before all 32 pixels returned.

Behaviour:
- Reset (rst=0 at a clk edge):
  - fb_req=0, fb_addr=0, mem_stb=0, mem_bgr_buf all 0, underrun=0.
  - Shadow buffer cleared; issue/return counters cleared; previous tuple register cleared (en=0); state IDLE.
  - Applies mid-fetch: any responses arriving after reset are ignored while in IDLE. Framebuffer memory must be reset together with this block.
- Tuple change (cycle N): true when en != prev_en, or when en=1 and (x_group != prev_group or y != prev_y). The prev_* registers update every cycle.
- Publish:
  - Condition: tuple change with prev_en=1.
  - At the edge ending cycle N, mem_bgr_buf <= shadow buffer, merged with any fb_rvalid beat arriving in cycle N.
  - mem_stb=1 during cycle N+1 only; mem_bgr_buf then holds until the next publish.
  - If the returned count (including that merged beat) is < 32: set underrun; unreturned entries carry the stale shadow contents.
- Start fetch:
  - Condition: tuple change with en=1.
  - Latch y and group; base = FB_BASE + y*LINE_PIX + group*GROUP_PIX. y*640 is computed as (y<<9)+(y<<7), zero-extended to ADDR_W.
  - Issue and return counters reset to 0. Next state is FETCH if no reads are outstanding, otherwise DRAIN.
- FSM:
  - IDLE: fb_req=0; wait for a start.
  - FETCH: fb_req=1 and fb_addr=base+issue_cnt while issue_cnt<32. On fb_gnt, issue_cnt++. On fb_rvalid, shadow[ret_cnt] <= fb_rdata and ret_cnt++. When ret_cnt reaches 32, go to IDLE.
  - DRAIN: fb_req=0; discard responses until outstanding (issued - returned) = 0, then go to FETCH for the latched tuple.
- A tuple change during FETCH aborts it: no further requests are issued, and in-flight responses are drained and discarded (via DRAIN) before the new fetch.
- Timing relationship: scan-out displays group g while x_group = g+1 (and after en falls, for the last group). Fetch therefore targets the current x_group; publish fires on leaving it.
- fb_req may be held across cycles without fb_gnt; fb_addr stays stable until granted.
- Counters are 6 bits; a pending grant and a response in the same cycle are both accounted for.

Decomposition:
- vga_pkg holds:
  - typedef pixel_t (logic [11:0]) and pix_group_t (pixel_t [31:0]).
  - H_ACTIVE=640, V_ACTIVE=480, GROUP_PIX=32, NUM_GROUPS=20.
  - FSM enum fetch_state_t {IDLE, FETCH, DRAIN}.
- One sub-module, vga_fetch_addr: combinational y/group -> base-address calculator, reused by the future framebuffer writer.

Test Plan:
- Reset: hold rst=0 for 3 cycles while driving fb_rvalid=1 -> all outputs 0; no fb_req; shadow not written.
- Single group, y=5, group=3, en=1, memory with zero-wait grant and 1-cycle latency, data = addr[11:0]:
  - fb_addr runs 3296..3327.
  - On the group change to 4: mem_stb pulses once, the cycle after the change, with mem_bgr_buf[i]=3296+i (12-bit truncated); underrun=0.
- Full line y=0: sweep groups 0..19 at 4 clk per pix tick, then drop en -> exactly 20 mem_stb pulses, the last one on en falling; each buffer matches its addresses 32g..32g+31.
- Underrun: gnt only every 8th cycle, and the group changes after 10 pixels returned -> mem_stb fires, underrun=1 (sticky); the new fetch starts only after outstanding reaches 0; stale entries 10..31 unchanged.
- Simultaneous: the 32nd fb_rvalid arrives in the same cycle as the tuple change -> published buffer includes pixel 31; underrun stays 0.
- Stall: fb_gnt=0 for 5 cycles at issue 7 -> fb_addr stays base+7 and fb_req stays 1 throughout; the fetch completes correctly.
